// File: rtl/bp_bram_frame_loader.sv
// bp_bram_frame_loader
// Purpose: on a start pulse from the register file, reads one frame of LLR
//   words from a 1-cycle-latency BRAM and streams them to the BP decoder core
//   over valid/ready. Reports busy/done/frame count back to the register file.
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   start, base_addr, frame_len  frame request (parameters sampled on accept)
//   busy, done, frame_cnt      status to the register file
//   bram_en, bram_addr, bram_dout  BRAM read port (data valid cycle after en)
//   m_tvalid, m_tdata, m_tlast, m_tready  LLR word stream to the decoder
//   abort, aborted             frame abort (only with BPD_LOADER_ABORT_EN)
// Build option: define BPD_LOADER_ABORT_EN to add the abort/aborted ports.
module bp_bram_frame_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_cnt,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready
`ifdef BPD_LOADER_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  bram_en_q, bram_en_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] obuf_q [2];
  logic [DATA_WIDTH-1:0] obuf_d [2];
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  aborted_q, aborted_d;

  logic buf_empty;
  logic hs;
  logic pop_buf;
  logic push;
  logic space_ok;

  // Stream head: buffered word if any, else the BRAM word arriving this cycle.
  assign buf_empty = (cnt_q == 2'd0);
  assign m_tvalid  = !buf_empty || rd_vld_q;
  assign m_tdata   = !buf_empty ? obuf_q[rd_ptr_q] :
                     (rd_vld_q ? bram_dout : '0);
  assign m_tlast   = m_tvalid && ((beat_cnt_q + LEN_WIDTH'(1)) == len_q);
  assign hs        = m_tvalid && m_tready;

  // An arriving word bypasses the buffer only when it is empty and accepted.
  assign pop_buf   = !buf_empty && m_tready;
  assign push      = rd_vld_q && !(buf_empty && m_tready);

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
`ifdef BPD_LOADER_ABORT_EN
  assign aborted   = aborted_q;
`endif

  // Next-state, buffer and status logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    rd_vld_d    = bram_en_q;
    obuf_d      = obuf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    aborted_d   = 1'b0;

    if (push) begin
      obuf_d[wr_ptr_q] = bram_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_buf) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop_buf);

    if (hs) begin
      beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
    end

    // A new read must fit next to the buffered words and the read in flight.
    space_ok = (cnt_d + 2'(bram_en_q)) <= 2'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            base_d      = base_addr;
            len_d       = frame_len;
            beat_cnt_d  = '0;
            issue_cnt_d = LEN_WIDTH'(1);
            bram_en_d   = 1'b1;
            bram_addr_d = base_addr;
            state_d     = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FETCH: begin
        if (hs && m_tlast) begin
          state_d = S_FIN;
        end else if (issue_cnt_q == len_q) begin
          state_d = S_DRAIN;
        end else if (space_ok) begin
          bram_en_d   = 1'b1;
          bram_addr_d = base_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
          if (issue_cnt_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (hs && m_tlast) begin
          state_d = S_FIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_FIN);
    if (state_d == S_FIN) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

`ifdef BPD_LOADER_ABORT_EN
    // Abort flushes the buffer and drops the read in flight.
    if (abort && ((state_q == S_FETCH) || (state_q == S_DRAIN))) begin
      state_d     = S_IDLE;
      bram_en_d   = 1'b0;
      rd_vld_d    = 1'b0;
      cnt_d       = 2'd0;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      aborted_d   = 1'b1;
    end
`endif
  end

  // State registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      rd_vld_q    <= 1'b0;
      obuf_q[0]   <= '0;
      obuf_q[1]   <= '0;
      cnt_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      rd_vld_q    <= rd_vld_d;
      obuf_q[0]   <= obuf_d[0];
      obuf_q[1]   <= obuf_d[1];
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      aborted_q   <= aborted_d;
    end
  end

endmodule

// File: tb/tb_bp_bram_frame_loader.sv
// tb_bp_bram_frame_loader
// Purpose: directed self-checking bench for bp_bram_frame_loader with a
//   1-cycle-latency BRAM model and a negedge stream monitor.
module tb_bp_bram_frame_loader;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] frame_len;
  logic        busy, done, bram_en, m_tvalid, m_tlast, m_tready;
  logic [15:0] frame_cnt;
  logic [9:0]  bram_addr;
  logic [31:0] bram_dout, m_tdata;
  logic        aborted_w;
`ifdef BPD_LOADER_ABORT_EN
  logic        abort;
`else
  assign aborted_w = 1'b0;
`endif

  always #5 ACLK = ~ACLK;

  bp_bram_frame_loader dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tready(m_tready)
`ifdef BPD_LOADER_ABORT_EN
    , .abort(abort), .aborted(aborted_w)
`endif
  );

  // BRAM model: registered read, data valid the cycle after bram_en.
  logic [31:0] mem [1024];
  always @(posedge ACLK) if (bram_en) bram_dout <= mem[bram_addr];

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor state.
  logic [31:0] bq_data [$];
  bit          bq_last [$];
  int          bq_cyc  [$];
  int          rd_addr [$];
  int          rd_cyc  [$];
  int          done_n, done_cyc, valid_n, aborted_n;
  int          rdy_mode = 0;
  int          pidx = 0;
  logic [5:0]  pat = 6'b101001;   // 1,0,0,1,0,1 from bit 0
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic clr();
    bq_data.delete(); bq_last.delete(); bq_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    done_n = 0; done_cyc = -1; valid_n = 0; aborted_n = 0; pidx = 0;
  endtask

  always @(negedge ACLK) begin
    case (rdy_mode)
      1:       begin m_tready = pat[pidx % 6]; pidx++; end
      2:       m_tready = (bq_data.size() < 3);
      default: m_tready = 1'b1;
    endcase
    #2;
    if (!ARESET) begin
      if (prev_stall && !aborted_w) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", 64'(m_tdata), 64'(prev_data));
        check("stall_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        bq_data.push_back(m_tdata); bq_last.push_back(m_tlast); bq_cyc.push_back(cyc);
      end
      if (bram_en) begin rd_addr.push_back(int'(bram_addr)); rd_cyc.push_back(cyc); end
      if (m_tvalid) valid_n++;
      if (done) begin done_n++; done_cyc = cyc; end
      if (aborted_w) aborted_n++;
    end
    prev_stall = !ARESET && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
  end

  int c0;

  task automatic launch(input int b, input int l);
    @(negedge ACLK);
    start = 1'b1; base_addr = 10'(b); frame_len = 11'(l); c0 = cyc;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_n == 0 && k < budget) begin @(negedge ACLK); #3; k++; end
    if (done_n == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (4) @(negedge ACLK);
    #3;
  endtask

  task automatic check_frame(input string tag, input int b, input int l);
    int nl;
    check({tag, "_beats"}, 64'(bq_data.size()), 64'(l));
    nl = 0;
    for (int i = 0; i < bq_data.size() && i < l; i++) begin
      check({tag, "_data"}, 64'(bq_data[i]), 64'(mem[(b + i) % 1024]));
      if (bq_last[i]) nl++;
    end
    if (bq_data.size() == l && l > 0) check({tag, "_last_pos"}, 64'(bq_last[l-1]), 64'd1);
    check({tag, "_last_cnt"}, 64'(nl), 64'd1);
    check({tag, "_done_cnt"}, 64'(done_n), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h4;
    ARESET = 1'b1; start = 1'b0; base_addr = '0; frame_len = '0;
`ifdef BPD_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    clr();
    repeat (3) @(negedge ACLK);
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_bram_en", 64'(bram_en), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // Basic 4-word frame, ready held high: exact cycle timing.
    clr(); rdy_mode = 0;
    launch(0, 4);
    #3;
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 50);
    check_frame("t1", 0, 4);
    if (rd_cyc.size() > 0) check("t1_first_rd_cyc", 64'(rd_cyc[0] - c0), 64'd1);
    for (int i = 0; i < bq_cyc.size() && i < 4; i++)
      check("t1_beat_cyc", 64'(bq_cyc[i] - c0), 64'(2 + i));
    check("t1_done_cyc", 64'(done_cyc - c0), 64'd6);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    // Same frame with a toggling ready.
    clr(); rdy_mode = 1;
    launch(0, 4);
    wait_done("t2", 80);
    check_frame("t2", 0, 4);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
    rdy_mode = 0;

    // Address wrap-around.
    clr();
    launch(10'h3FE, 4);
    wait_done("t3", 50);
    check_frame("t3", 10'h3FE, 4);
    check("t3_rd_n", 64'(rd_addr.size()), 64'd4);
    for (int i = 0; i < rd_addr.size() && i < 4; i++)
      check("t3_rd_addr", 64'(rd_addr[i]), 64'((1022 + i) % 1024));
    check("t3_frame_cnt", 64'(frame_cnt), 64'd3);

    // Zero-length frame.
    clr();
    launch(5, 0);
    wait_done("t4", 20);
    check("t4_rd_n", 64'(rd_addr.size()), 64'd0);
    check("t4_valid_n", 64'(valid_n), 64'd0);
    check("t4_done_cyc", 64'(done_cyc - c0), 64'd1);
    check("t4_done_cnt", 64'(done_n), 64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

    // Start while busy is ignored.
    clr();
    launch(10'h040, 8);
    @(negedge ACLK);
    start = 1'b1; base_addr = 10'h100; frame_len = 11'd2;
    @(negedge ACLK);
    start = 1'b0;
    wait_done("t5", 60);
    check_frame("t5", 10'h040, 8);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd5);

    // Reset mid-frame, then a clean 2-word frame.
    clr();
    launch(10'h080, 16);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    #3;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t6_bram_en", 64'(bram_en), 64'd0);
    check("t6_bram_addr", 64'(bram_addr), 64'd0);
    check("t6_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_tdata", 64'(m_tdata), 64'd0);
    check("t6_tlast", 64'(m_tlast), 64'd0);
    check("t6_no_done", 64'(done_n), 64'd0);
    clr();
    launch(10'h200, 2);
    wait_done("t6b", 40);
    check_frame("t6b", 10'h200, 2);
    check("t6b_frame_cnt", 64'(frame_cnt), 64'd1);

`ifdef BPD_LOADER_ABORT_EN
    // Abort after 3 beats with the consumer stalled.
    clr(); rdy_mode = 2;
    launch(10'h020, 10);
    for (int k = 0; k < 40 && bq_data.size() < 3; k++) begin @(negedge ACLK); #3; end
    check("t7_beats_before", 64'(bq_data.size()), 64'd3);
    repeat (2) @(negedge ACLK);
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    #3;
    check("t7_aborted", 64'(aborted_w), 64'd1);
    check("t7_tvalid", 64'(m_tvalid), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    rdy_mode = 0;
    repeat (6) @(negedge ACLK);
    #3;
    check("t7_beats_after", 64'(bq_data.size()), 64'd3);
    check("t7_aborted_n", 64'(aborted_n), 64'd1);
    check("t7_no_done", 64'(done_n), 64'd0);
    check("t7_frame_cnt", 64'(frame_cnt), 64'd1);
    clr();
    launch(0, 4);
    wait_done("t7b", 40);
    check_frame("t7b", 0, 4);
    check("t7b_frame_cnt", 64'(frame_cnt), 64'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
